// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared FSM state, default sizes and command layout for seq_pattern_gen.
package seq_gen_pkg;
    localparam int DEF_LEN_W      = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    typedef enum logic {IDLE, RUN} state_t;
    typedef struct packed {
        logic                 val;
        logic [DEF_LEN_W-1:0] len;
    } cmd_t;
endpackage

// File: rtl/seq_cmd_fifo.sv
// seq_cmd_fifo: synchronous command FIFO; extra pointer MSB tells full from empty.
module seq_cmd_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    logic [AW:0]  wptr_q, rptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         wr, rd;
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = wptr_q == rptr_q;
    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wr ? wptr_q + PTR_ONE : wptr_q;
            rptr_q <= rd ? rptr_q + PTR_ONE : rptr_q;
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serialises queued {bit, run length} commands onto w, one bit per clock.
// Define SEQ_GEN_CHECK_EN to add the z_exp golden-model output for the sequence detector.
module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int LEN_W      = DEF_LEN_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter bit IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_bit,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             w,
    output logic             w_valid,
    output logic             run_done,
    output logic             busy
`ifdef SEQ_GEN_CHECK_EN
    ,
    output logic             z_exp
`endif
);
    localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);
    localparam logic [LEN_W:0] CNT_TWO = (LEN_W+1)'(2);
    state_t           state_q;
    logic [LEN_W:0]   cnt_q;
    logic             w_q, w_valid_q, run_done_q;
    logic             full, empty, push, pop;
    logic [LEN_W:0]   head_data, load_len;
    logic             head_bit;
    logic [LEN_W-1:0] head_len;
    seq_cmd_fifo #(.W(LEN_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({cmd_bit, cmd_len}),
        .rdata (head_data),
        .full  (full),
        .empty (empty)
    );
    assign cmd_ready = !full;
    assign push      = cmd_valid && cmd_ready;
    assign head_bit  = head_data[LEN_W];
    assign head_len  = head_data[LEN_W-1:0];
    // A zero length sets only the extra MSB, i.e. 2**LEN_W.
    assign load_len  = {head_len == '0, head_len};
    assign pop       = !empty && (state_q == IDLE || cnt_q == CNT_ONE);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            w_q        <= IDLE_BIT;
            w_valid_q  <= 1'b0;
            run_done_q <= 1'b0;
        end else if (pop) begin
            state_q    <= RUN;
            cnt_q      <= load_len;
            w_q        <= head_bit;
            w_valid_q  <= 1'b1;
            run_done_q <= load_len == CNT_ONE;
        end else if (state_q == RUN && cnt_q != CNT_ONE) begin
            cnt_q      <= cnt_q - CNT_ONE;
            run_done_q <= cnt_q == CNT_TWO;
        end else begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            w_q        <= IDLE_BIT;
            w_valid_q  <= 1'b0;
            run_done_q <= 1'b0;
        end
    end
    assign w        = w_q;
    assign w_valid  = w_valid_q;
    assign run_done = run_done_q;
    assign busy     = state_q == RUN || !empty;
`ifdef SEQ_GEN_CHECK_EN
    logic [3:0] hist_q;
    logic [2:0] fill_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= {hist_q[2:0], w_q};
            fill_q <= (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
        end
    end
    assign z_exp = w_q && fill_q == 3'd4 && (hist_q == 4'h0 || hist_q == 4'hF);
`endif
endmodule
